// File: rtl/dual_dmem_responder.sv
// dual_dmem_responder
//
// Data-memory responder for the memory stage of a two-issue MIPS pipeline
// (slot 0 older, slot 1 younger). Word storage is split into two single-ported
// banks interleaved on byte-address bit 2. Accesses to different banks run in
// parallel. A same-bank pair runs slot 0 first and parks slot 1 in a pending
// register for one cycle, raising a one-cycle stall. Read data returns one
// cycle after the bank access.
//
// Ports:
//   i_clk                rising-edge clock
//   i_reset              asynchronous active-high reset
//   i_req_x / i_we_x     slot-x request / write enable (0 = read)
//   i_addr_x             slot-x byte address (bits [1:0] and above ADDR_W+1 ignored)
//   i_wdata_x            slot-x store data
//   o_stall              combinational; high while a conflict is being serialized
//   o_rvalid_x           one-cycle pulse when slot-x read data is returned
//   o_rdata_x            slot-x read data, held until the next slot-x read
module dual_dmem_responder #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_0,
    input  logic        i_we_0,
    input  logic [31:0] i_addr_0,
    input  logic [31:0] i_wdata_0,
    input  logic        i_req_1,
    input  logic        i_we_1,
    input  logic [31:0] i_addr_1,
    input  logic [31:0] i_wdata_1,
    output logic        o_stall,
    output logic        o_rvalid_0,
    output logic [31:0] o_rdata_0,
    output logic        o_rvalid_1,
    output logic [31:0] o_rdata_1
);

    localparam int unsigned RowW  = ADDR_W - 1;
    localparam int unsigned Depth = 1 << RowW;

    typedef enum logic [0:0] {StIdle, StPend} state_e;

    state_e r_state;
    state_e w_state_next;

    // Address decode
    logic            w_bank_0;
    logic            w_bank_1;
    logic [RowW-1:0] w_row_0;
    logic [RowW-1:0] w_row_1;

    assign w_bank_0 = i_addr_0[2];
    assign w_bank_1 = i_addr_1[2];
    assign w_row_0  = i_addr_0[ADDR_W+1:3];
    assign w_row_1  = i_addr_1[ADDR_W+1:3];

    // Byte offset and wrap-around bits are intentionally dropped.
    logic w_unused;
    assign w_unused = ^{i_addr_0[1:0], i_addr_0[31:ADDR_W+2],
                        i_addr_1[1:0], i_addr_1[31:ADDR_W+2]};

    // Pending slot-1 access parked during a conflict
    logic            r_p_we;
    logic            r_p_bank;
    logic [RowW-1:0] r_p_row;
    logic [31:0]     r_p_wdata;

    logic w_idle;
    logic w_conflict;
    logic w_go_0;
    logic w_go_1;
    logic w_go_p;

    assign w_idle     = (r_state == StIdle);
    assign w_conflict = w_idle & i_req_0 & i_req_1 & (w_bank_0 == w_bank_1);
    assign w_go_0     = w_idle & i_req_0;
    assign w_go_1     = w_idle & i_req_1 & ~w_conflict;
    // While pending, the frozen CPU's held inputs are ignored.
    assign w_go_p     = (r_state == StPend);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_conflict) w_state_next = StPend;
            StPend:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // FSM: outputs. Stall depends only on requests, bank bits and state.
    always_comb begin
        o_stall = w_conflict & ~i_reset;
    end

    // Pending register; cleared by reset so a parked access is dropped.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_p_we    <= 1'b0;
            r_p_bank  <= 1'b0;
            r_p_row   <= '0;
            r_p_wdata <= '0;
        end else if (w_conflict) begin
            r_p_we    <= i_we_1;
            r_p_bank  <= w_bank_1;
            r_p_row   <= w_row_1;
            r_p_wdata <= i_wdata_1;
        end
    end

    // ------------------------------------------------------------------
    // Bank arbitration: slot 0, then slot 1, then the pending access.
    // In IDLE a same-bank slot 1 is already excluded via w_go_1.
    // ------------------------------------------------------------------
    logic [1:0]      w_bk_en;
    logic [1:0]      w_bk_we;
    logic [RowW-1:0] w_bk_row   [2];
    logic [31:0]     w_bk_wdata [2];

    always_comb begin
        w_bk_en    = '0;
        w_bk_we    = '0;
        w_bk_row   = '{default: '0};
        w_bk_wdata = '{default: '0};
        for (int b = 0; b < 2; b++) begin
            if (w_go_0 && (w_bank_0 == 1'(b))) begin
                w_bk_en[b]    = 1'b1;
                w_bk_we[b]    = i_we_0;
                w_bk_row[b]   = w_row_0;
                w_bk_wdata[b] = i_wdata_0;
            end else if (w_go_1 && (w_bank_1 == 1'(b))) begin
                w_bk_en[b]    = 1'b1;
                w_bk_we[b]    = i_we_1;
                w_bk_row[b]   = w_row_1;
                w_bk_wdata[b] = i_wdata_1;
            end else if (w_go_p && (r_p_bank == 1'(b))) begin
                w_bk_en[b]    = 1'b1;
                w_bk_we[b]    = r_p_we;
                w_bk_row[b]   = r_p_row;
                w_bk_wdata[b] = r_p_wdata;
            end
        end
    end

    // Memory banks: one write or one synchronous read per bank per cycle.
    logic [31:0] r_mem  [2][Depth];
    logic [31:0] r_bk_q [2];

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 2; b++) begin
            if (w_bk_en[b]) begin
                if (w_bk_we[b]) begin
                    r_mem[b][w_bk_row[b]] <= w_bk_wdata[b];
                end else begin
                    r_bk_q[b] <= r_mem[b][w_bk_row[b]];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response tracking: which bank each slot's read used, plus a hold
    // register so rdata keeps its value after the bank output moves on.
    // ------------------------------------------------------------------
    logic w_rd_0;
    logic w_rd_1;
    logic w_rbank_1;

    assign w_rd_0    = w_go_0 & ~i_we_0;
    assign w_rd_1    = (w_go_1 & ~i_we_1) | (w_go_p & ~r_p_we);
    assign w_rbank_1 = w_go_p ? r_p_bank : w_bank_1;

    logic        r_rvalid_0;
    logic        r_rvalid_1;
    logic        r_rbank_0;
    logic        r_rbank_1;
    logic [31:0] r_hold_0;
    logic [31:0] r_hold_1;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rvalid_0 <= 1'b0;
            r_rvalid_1 <= 1'b0;
            r_rbank_0  <= 1'b0;
            r_rbank_1  <= 1'b0;
            r_hold_0   <= '0;
            r_hold_1   <= '0;
        end else begin
            r_rvalid_0 <= w_rd_0;
            r_rvalid_1 <= w_rd_1;
            if (w_rd_0) r_rbank_0 <= w_bank_0;
            if (w_rd_1) r_rbank_1 <= w_rbank_1;
            if (r_rvalid_0) r_hold_0 <= r_bk_q[r_rbank_0];
            if (r_rvalid_1) r_hold_1 <= r_bk_q[r_rbank_1];
        end
    end

    assign o_rvalid_0 = r_rvalid_0;
    assign o_rvalid_1 = r_rvalid_1;
    assign o_rdata_0  = r_rvalid_0 ? r_bk_q[r_rbank_0] : r_hold_0;
    assign o_rdata_1  = r_rvalid_1 ? r_bk_q[r_rbank_1] : r_hold_1;

endmodule

// File: doc/dual_dmem_responder.md
# dual_dmem_responder

Dual-lane data-memory responder serving the memory stage of the two-issue superscalar MIPS CPU (slot 0 older, slot 1 younger). It holds word storage split into two single-ported banks interleaved on address bit 2. Non-conflicting slot accesses proceed in parallel. A same-bank conflict serializes slot 1 behind slot 0 and raises a one-cycle pipeline stall. Read data returns one cycle after the bank access, on the readdata lines the CPU exposes as readdata_m_0 / readdata_m_1.

## Interface
- ADDR_W, 10: total word-address bits (2^ADDR_W words; 2^(ADDR_W-1) per bank)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_0  in  1  slot-0 access request this cycle
- we_0  in  1  slot-0 write enable (0 = read)
- addr_0  in  32  slot-0 byte address (aluout_m_0)
- wdata_0  in  32  slot-0 store data
- req_1 / we_1 / addr_1 / wdata_1  in  1/1/32/32  slot-1 equivalents
- stall  out  1  combinational; high when a conflict is being serialized this cycle
- rvalid_0  out  1  slot-0 read data valid
- rdata_0  out  32  slot-0 read data (readdata_m_0)
- rvalid_1  out  1  slot-1 read data valid
- rdata_1  out  32  slot-1 read data (readdata_m_1)

## Operation
- Address decode: addr[1:0] ignored; bank = addr[2]; row = addr[ADDR_W+1:3]; bits above ADDR_W+1 ignored (wrap-around).
- Each bank does at most one access per cycle: a write or a synchronous read.
- States: IDLE and PEND (one pending slot-1 request register).
- IDLE, no conflict (at most one req, or both reqs to different banks):
  - both slots access their banks this cycle;
  - stall = 0.
- IDLE, conflict (req_0 & req_1 & same bank, any mix of read/write, including identical addresses):
  - slot 0 accesses the bank;
  - slot 1 {we, row, bank, wdata} is captured into the pending register;
  - stall = 1;
  - go to PEND.
- PEND:
  - all request inputs are ignored (the CPU is frozen and holds them);
  - the pending slot-1 access is performed;
  - stall = 0;
  - return to IDLE.
  - In the following cycle, inputs are sampled again as new requests.
- Ordering guarantees:
  - Slot 0 always precedes slot 1.
  - Slot-0 write then slot-1 read of the same word: slot 1 returns the new data.
  - Both slots write the same word: slot-1 data remains.
  - Slot-0 read with slot-1 write to the same word: slot 0 returns the old data.
- Reads: rvalid_x pulses for exactly one cycle, and rdata_x holds its value until the next read for that slot. Writes produce no response.
- Reset: asynchronous, no clock required.
  - State returns to IDLE and the pending register is cleared (a pending access is dropped, never performed).
  - rvalid_0 = rvalid_1 = 0; rdata_0 = rdata_1 = 0; stall = 0 while reset is high.
  - Memory array contents are not reset.

## Timing
- Bank access in cycle N (no conflict) produces rvalid/rdata at N+1.
- Conflict in cycle N:
  - slot 0 response at N+1;
  - stall high during N only;
  - slot-1 access at N+1, response at N+2.
- Write latency: 1 cycle. A read of the same word in the next cycle sees the written data.
- stall depends only on req_0, req_1, addr_0[2], addr_1[2] and state. It has no path from the memory array.
- Back-to-back conflicts: IDLE→PEND→IDLE→PEND is legal, so stall is high every other cycle.
- Reset deasserting mid-stream: the first request is accepted on the first rising edge with reset low.

## Test plan
- Reset, then write_0 addr 0x0000_0010 data 0xDEAD_BEEF; next cycle read_0 same address -> rvalid_0 two cycles after the write, rdata_0 = 0xDEAD_BEEF; stall never asserted.
- Same cycle: read_0 0x00 and read_1 0x04 (different banks, preloaded 0x11 and 0x22) -> stall = 0; one cycle later rvalid_0 = rvalid_1 = 1, rdata_0 = 0x11, rdata_1 = 0x22.
- Same cycle: write_0 0x08 = 0xAAAA_0000 and read_1 0x08 -> stall = 1 for one cycle; rdata_1 = 0xAAAA_0000 at N+2; no slot-1 response at N+1.
- Same cycle: write_0 and write_1 to 0x20 (0x1 and 0x2) -> stall pulse; a later read of 0x20 returns 0x2. Also check wrap: with ADDR_W = 10, a read of 0x0000_1020 returns 0x2.
- Conflict in cycle N with reset asserted asynchronously mid-cycle N+1 (before the PEND edge): pending write_1 to 0x30 = 0x55 is dropped (later read returns the prior value 0x0); rvalid_0/1 and stall go to 0 immediately.
- Three consecutive cycles of same-bank read pairs -> stall pattern 1,0,1; responses in program order; rvalid never asserted for write-only slots.
